// File: rtl/control_unit_pipe.sv
// control_unit_pipe: RV32I main decoder with a registered EX-stage control
// bundle, load-use hazard detection and a saturating illegal-instruction counter.
module control_unit_pipe #(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid_i,
    input  logic [31:0]          instr_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic                 hazard_stall_o,
    output logic                 ex_valid_o,
    output logic                 ex_RegWrite,
    output logic                 ex_ALUSrc,
    output logic                 ex_MemWrite,
    output logic                 ex_MemRead,
    output logic                 ex_Branch,
    output logic                 ex_Jump,
    output logic                 ex_Jalr,
    output logic [1:0]           ex_ResultSrc,
    output logic [2:0]           ex_ImmSrc,
    output logic [ALUCTRL_W-1:0] ex_ALUControl,
    output logic [4:0]           ex_rd,
    output logic                 ex_illegal_o,
    output logic [CNT_W-1:0]     illegal_cnt_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       alusrc;
        logic       memwrite;
        logic       memread;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] resultsrc;
        logic [2:0] immsrc;
        logic [3:0] aluctrl;
        logic [4:0] rd;
        logic       illegal;
    } ctrl_t;

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic           use_rs1;
    logic           use_rs2;
    logic           load_en;
    ctrl_t          dec;
    ctrl_t          ex;
    logic [CNT_W-1:0] illegal_cnt;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];

    // Shared funct3 -> ALU op table for the R and I arithmetic forms.
    function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                            input logic sub_sel,
                                            input logic sra_sel);
        logic [3:0] op;
        case (f3)
            3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_sel ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Decode the instruction word into a control bundle; illegal or invalid words collapse to safe zeros.
    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec.rd  = instr_i[11:7];
        case (opcode)
            OP_R: begin
                dec.regwrite = 1'b1;
                dec.aluctrl  = arith_op(funct3, funct7[5], funct7[5]);
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                if (!((funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    dec.illegal = 1'b1;
            end
            OP_I: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluctrl  = arith_op(funct3, 1'b0, funct7[5]);
                use_rs1      = 1'b1;
            end
            OP_LOAD: begin
                dec.regwrite  = 1'b1;
                dec.alusrc    = 1'b1;
                dec.memread   = 1'b1;
                dec.resultsrc = 2'b01;
                use_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.immsrc   = 3'b001;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.immsrc = 3'b010;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                case (funct3[2:1])
                    2'b00:   dec.aluctrl = ALU_SUB;
                    2'b10:   dec.aluctrl = ALU_SLT;
                    2'b11:   dec.aluctrl = ALU_SLTU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.regwrite  = 1'b1;
                dec.alusrc    = 1'b1;
                dec.jump      = 1'b1;
                dec.resultsrc = 2'b10;
                dec.immsrc    = 3'b011;
            end
            OP_JALR: begin
                dec.regwrite  = 1'b1;
                dec.alusrc    = 1'b1;
                dec.jalr      = 1'b1;
                dec.resultsrc = 2'b10;
                use_rs1       = 1'b1;
            end
            OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.immsrc   = 3'b100;
                dec.aluctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.immsrc   = 3'b100;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.valid = instr_valid_i;
        if (!instr_valid_i) begin
            dec     = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    // Load-use hazard: a load in EX whose destination feeds the instruction now in decode.
    always_comb begin
        hazard_stall_o = !stall_i && !flush_i && ex.valid && ex.memread &&
                         (ex.rd != 5'd0) && instr_valid_i &&
                         ((use_rs1 && rs1 == ex.rd) || (use_rs2 && rs2 == ex.rd));
    end

    assign load_en = !flush_i && !stall_i && !hazard_stall_o;

    // EX register: flush kills, stall holds, hazard inserts a bubble, otherwise load the decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ex <= '0;
        else if (flush_i)
            ex <= '0;
        else if (stall_i)
            ex <= ex;
        else if (hazard_stall_o)
            ex <= '0;
        else
            ex <= dec;
    end

    // Count valid illegal instructions as they enter EX, sticking at the all-ones value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            illegal_cnt <= '0;
        else if (load_en && dec.valid && dec.illegal && illegal_cnt != {CNT_W{1'b1}})
            illegal_cnt <= illegal_cnt + 1'b1;
    end

    assign ex_valid_o    = ex.valid;
    assign ex_RegWrite   = ex.regwrite;
    assign ex_ALUSrc     = ex.alusrc;
    assign ex_MemWrite   = ex.memwrite;
    assign ex_MemRead    = ex.memread;
    assign ex_Branch     = ex.branch;
    assign ex_Jump       = ex.jump;
    assign ex_Jalr       = ex.jalr;
    assign ex_ResultSrc  = ex.resultsrc;
    assign ex_ImmSrc     = ex.immsrc;
    assign ex_ALUControl = ALUCTRL_W'(ex.aluctrl);
    assign ex_rd         = ex.rd;
    assign ex_illegal_o  = ex.illegal;
    assign illegal_cnt_o = illegal_cnt;

endmodule

// File: tb/tb_control_unit_pipe.sv
// tb_control_unit_pipe: scoreboard-driven bench for the decode/EX control unit.
module tb_control_unit_pipe;

    logic        clk;
    logic        rst;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic        stall_i;
    logic        flush_i;
    logic        hazard_stall_o;
    logic        ex_valid_o;
    logic        ex_RegWrite;
    logic        ex_ALUSrc;
    logic        ex_MemWrite;
    logic        ex_MemRead;
    logic        ex_Branch;
    logic        ex_Jump;
    logic        ex_Jalr;
    logic [1:0]  ex_ResultSrc;
    logic [2:0]  ex_ImmSrc;
    logic [3:0]  ex_ALUControl;
    logic [4:0]  ex_rd;
    logic        ex_illegal_o;
    logic [7:0]  illegal_cnt_o;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic [22:0] exp_q[$];
    logic [22:0] exp;
    logic [22:0] obs;

    control_unit_pipe #(.ALUCTRL_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
        .stall_i(stall_i), .flush_i(flush_i), .hazard_stall_o(hazard_stall_o),
        .ex_valid_o(ex_valid_o), .ex_RegWrite(ex_RegWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead), .ex_Branch(ex_Branch),
        .ex_Jump(ex_Jump), .ex_Jalr(ex_Jalr), .ex_ResultSrc(ex_ResultSrc),
        .ex_ImmSrc(ex_ImmSrc), .ex_ALUControl(ex_ALUControl), .ex_rd(ex_rd),
        .ex_illegal_o(ex_illegal_o), .illegal_cnt_o(illegal_cnt_o)
    );

    assign obs = {ex_valid_o, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_Branch,
                  ex_Jump, ex_Jalr, ex_ResultSrc, ex_ImmSrc, ex_ALUControl, ex_rd, ex_illegal_o};

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a reported failure.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [22:0] mk(input logic v, input logic rw, input logic as,
                                       input logic mw, input logic mr, input logic br,
                                       input logic j, input logic jr, input logic [1:0] rs,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic [4:0] rd, input logic ill);
        return {v, rw, as, mw, mr, br, j, jr, rs, imm, alu, rd, ill};
    endfunction

    localparam logic [31:0] I_ADD3  = 32'h002081B3;
    localparam logic [31:0] I_LW5   = 32'h0000A283;
    localparam logic [31:0] I_ADD6  = 32'h00028333;
    localparam logic [31:0] I_SW5   = 32'h00512023;
    localparam logic [31:0] I_LW0   = 32'h0000A003;
    localparam logic [31:0] I_ADD00 = 32'h00000333;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        instr_i       = ins;
        instr_valid_i = v;
        stall_i       = st;
        flush_i       = fl;
    endtask

    // Asynchronous reset clears everything and holds across a clock edge.
    task automatic test_reset();
        drive(I_ADD3, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        #3;
        checks++;
        if (obs !== 23'd0) begin errors++; $display("[TB] FAIL reset_bundle: got %h expected %h", obs, 23'd0); end
        tick();
        checks++;
        if (obs !== 23'd0 || illegal_cnt_o !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_hold: got %h/%0d expected 0/0", obs, illegal_cnt_o);
        end
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    // Decode table: one instruction per cycle, result one cycle later.
    task automatic test_decode();
        logic [31:0] ins [18];
        logic        vld [18];
        logic [22:0] e   [18];
        ins[0]  = I_ADD3;       vld[0]  = 1; e[0]  = mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd3,0);
        ins[1]  = 32'h40208133; vld[1]  = 1; e[1]  = mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd1,5'd2,0);
        ins[2]  = 32'h4030D093; vld[2]  = 1; e[2]  = mk(1,1,1,0,0,0,0,0,2'b00,3'b000,4'd9,5'd1,0);
        ins[3]  = 32'h0020F1B3; vld[3]  = 1; e[3]  = mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd2,5'd3,0);
        ins[4]  = 32'hFFF0C213; vld[4]  = 1; e[4]  = mk(1,1,1,0,0,0,0,0,2'b00,3'b000,4'd4,5'd4,0);
        ins[5]  = 32'h0020D1B3; vld[5]  = 1; e[5]  = mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd8,5'd3,0);
        ins[6]  = 32'h4020D1B3; vld[6]  = 1; e[6]  = mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd9,5'd3,0);
        ins[7]  = 32'h123452B7; vld[7]  = 1; e[7]  = mk(1,1,1,0,0,0,0,0,2'b00,3'b100,4'd10,5'd5,0);
        ins[8]  = 32'h00001397; vld[8]  = 1; e[8]  = mk(1,1,1,0,0,0,0,0,2'b00,3'b100,4'd0,5'd7,0);
        ins[9]  = 32'h00208063; vld[9]  = 1; e[9]  = mk(1,0,0,0,0,1,0,0,2'b00,3'b010,4'd1,5'd0,0);
        ins[10] = 32'h0020C063; vld[10] = 1; e[10] = mk(1,0,0,0,0,1,0,0,2'b00,3'b010,4'd5,5'd0,0);
        ins[11] = 32'h0020F063; vld[11] = 1; e[11] = mk(1,0,0,0,0,1,0,0,2'b00,3'b010,4'd6,5'd0,0);
        ins[12] = 32'h0020A023; vld[12] = 1; e[12] = mk(1,0,1,1,0,0,0,0,2'b00,3'b001,4'd0,5'd0,0);
        ins[13] = 32'h022081B3; vld[13] = 1; e[13] = mk(1,0,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd0,1);
        ins[14] = 32'h0020A063; vld[14] = 1; e[14] = mk(1,0,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd0,1);
        ins[15] = 32'h4020F1B3; vld[15] = 1; e[15] = mk(1,0,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd0,1);
        ins[16] = I_ADD3;       vld[16] = 0; e[16] = 23'd0;
        ins[17] = 32'h0020A1B3; vld[17] = 1; e[17] = mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd5,5'd3,0);
        for (int i = 0; i < 18; i++) begin
            drive(ins[i], vld[i], 1'b0, 1'b0);
            exp_q.push_back(e[i]);
            if (vld[i] && e[i][0]) exp_cnt++;
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++; $display("[TB] FAIL decode_%0d (%h): got %h expected %h", i, ins[i], obs, exp);
            end
        end
        checks++;
        if (illegal_cnt_o !== 8'(exp_cnt)) begin
            errors++; $display("[TB] FAIL decode_cnt: got %0d expected %0d", illegal_cnt_o, exp_cnt);
        end
    endtask

    // Load-use hazard: one bubble, interaction with stall and flush, x0 exemption.
    task automatic test_hazard();
        logic [22:0] lw5, add6, sw5;
        lw5  = mk(1,1,1,0,1,0,0,0,2'b01,3'b000,4'd0,5'd5,0);
        add6 = mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd6,0);
        sw5  = mk(1,0,1,1,0,0,0,0,2'b00,3'b001,4'd0,5'd0,0);

        drive(I_LW5, 1'b1, 1'b0, 1'b0); exp_q.push_back(lw5); tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL hz_lw: got %h expected %h", obs, exp); end
        drive(I_ADD6, 1'b1, 1'b0, 1'b0); #1;
        checks++;
        if (hazard_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL hz_detect: got %b expected 1", hazard_stall_o); end
        exp_q.push_back(23'd0); tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL hz_bubble: got %h expected %h", obs, exp); end
        checks++;
        if (hazard_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL hz_one_cycle: got %b expected 0", hazard_stall_o); end
        exp_q.push_back(add6); tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL hz_add6: got %h expected %h", obs, exp); end

        drive(I_LW5, 1'b1, 1'b0, 1'b0); tick();
        drive(I_SW5, 1'b1, 1'b1, 1'b0); #1;
        checks++;
        if (hazard_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL hz_masked_stall: got %b expected 0", hazard_stall_o); end
        exp_q.push_back(lw5); tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL hz_stall_hold: got %h expected %h", obs, exp); end
        stall_i = 1'b0; #1;
        checks++;
        if (hazard_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL hz_rs2: got %b expected 1", hazard_stall_o); end
        exp_q.push_back(23'd0); tick();
        exp_q.push_back(sw5); tick();
        exp = exp_q.pop_front(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL hz_sw5: got %h expected %h", obs, exp); end

        drive(I_LW5, 1'b1, 1'b0, 1'b0); tick();
        drive(I_ADD6, 1'b1, 1'b0, 1'b1); #1;
        checks++;
        if (hazard_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL hz_masked_flush: got %b expected 0", hazard_stall_o); end
        exp_q.push_back(23'd0); tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL hz_flush_kill: got %h expected %h", obs, exp); end

        drive(I_LW0, 1'b1, 1'b0, 1'b0); tick();
        drive(I_ADD00, 1'b1, 1'b0, 1'b0); #1;
        checks++;
        if (hazard_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL hz_x0: got %b expected 0", hazard_stall_o); end
        exp_q.push_back(add6); tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL hz_x0_load: got %h expected %h", obs, exp); end
    endtask

    // Stall holds both the EX bundle and the illegal counter.
    task automatic test_stall_hold();
        logic [22:0] add3, ill;
        add3 = mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd3,0);
        ill  = mk(1,0,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd0,1);
        drive(I_ADD3, 1'b1, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(I_ILL, 1'b1, 1'b1, 1'b0);
            exp_q.push_back(add3); tick();
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp || illegal_cnt_o !== 8'(exp_cnt)) begin
                errors++; $display("[TB] FAIL stall_hold_%0d: got %h/%0d expected %h/%0d", i, obs, illegal_cnt_o, exp, exp_cnt);
            end
        end
        drive(I_ILL, 1'b1, 1'b0, 1'b0); exp_q.push_back(ill); exp_cnt++; tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp || illegal_cnt_o !== 8'(exp_cnt)) begin
            errors++; $display("[TB] FAIL stall_release: got %h/%0d expected %h/%0d", obs, illegal_cnt_o, exp, exp_cnt);
        end
        drive(I_ILL, 1'b1, 1'b1, 1'b0); tick();
        checks++;
        if (illegal_cnt_o !== 8'(exp_cnt)) begin
            errors++; $display("[TB] FAIL stall_cnt_hold: got %0d expected %0d", illegal_cnt_o, exp_cnt);
        end
    endtask

    // JAL decode, then a flush that wins over a simultaneous stall.
    task automatic test_flush_jal();
        logic [13:0] got;
        drive(I_JAL, 1'b1, 1'b0, 1'b0); tick();
        got = {ex_valid_o, ex_Jump, ex_ResultSrc, ex_ImmSrc, ex_RegWrite, ex_rd, ex_MemWrite};
        checks++;
        if (got !== {1'b1, 1'b1, 2'b10, 3'b011, 1'b1, 5'd1, 1'b0}) begin
            errors++; $display("[TB] FAIL jal_fields: got %h expected %h", got, {1'b1, 1'b1, 2'b10, 3'b011, 1'b1, 5'd1, 1'b0});
        end
        drive(I_ADD3, 1'b1, 1'b1, 1'b1); exp_q.push_back(23'd0); tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL flush_over_stall: got %h expected %h", obs, exp); end
    endtask

    // Reset arriving while a hazard is pending discards it; first edge after loads normally.
    task automatic test_reset_mid_hazard();
        drive(I_LW5, 1'b1, 1'b0, 1'b0); tick();
        drive(I_ADD6, 1'b1, 1'b0, 1'b0); #1;
        rst = 1'b0; #1;
        exp_cnt = 0;
        checks++;
        if (obs !== 23'd0 || illegal_cnt_o !== 8'd0 || hazard_stall_o !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_hazard: got %h/%0d/%b expected 0/0/0", obs, illegal_cnt_o, hazard_stall_o);
        end
        rst = 1'b1;
        exp_q.push_back(mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd6,0)); tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL rst_first_load: got %h expected %h", obs, exp); end
    endtask

    // 300 back-to-back illegal words saturate the counter; reset clears it immediately.
    task automatic test_illegal_saturation();
        for (int i = 0; i < 300; i++) begin
            drive(I_ILL, 1'b1, 1'b0, 1'b0);
            exp_q.push_back(mk(1,0,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd0,1));
            if (exp_cnt < 255) exp_cnt++;
            tick();
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp || illegal_cnt_o !== 8'(exp_cnt)) begin
                errors++; $display("[TB] FAIL sat_%0d: got %h/%0d expected %h/%0d", i, obs, illegal_cnt_o, exp, exp_cnt);
            end
        end
        checks++;
        if (illegal_cnt_o !== 8'd255) begin errors++; $display("[TB] FAIL sat_final: got %0d expected 255", illegal_cnt_o); end
        #2;
        rst = 1'b0; #1;
        exp_cnt = 0;
        checks++;
        if (illegal_cnt_o !== 8'd0 || obs !== 23'd0) begin
            errors++; $display("[TB] FAIL sat_async_clear: got %0d/%h expected 0/0", illegal_cnt_o, obs);
        end
        rst = 1'b1;
        drive(I_ADD3, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(mk(1,1,0,0,0,0,0,0,2'b00,3'b000,4'd0,5'd3,0)); tick();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL sat_reload: got %h expected %h", obs, exp); end
    endtask

    // Run every scenario in order and report.
    initial begin
        rst = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_decode();
        test_hazard();
        test_stall_hold();
        test_flush_jal();
        test_reset_mid_hazard();
        test_illegal_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
